// File: rtl/stream_video_pattern_gen_if.sv
// AXI4-Stream video channel: 24-bit pixel with start-of-frame (tuser) and end-of-line (tlast).
interface stream_video_pattern_gen_if #(
  parameter int DATA_W = 24
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tuser;
  logic              tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/stream_video_pattern_gen.sv
// Synthetic video frame source: one pixel per cycle, SOF on tuser, EOL on tlast,
// single or continuous frames with an optional idle gap, full backpressure support.
module stream_video_pattern_gen #(
  parameter int  MAX_IMG_RES = 1024,
  parameter int  FRAME_GAP   = 16,
  localparam int CW          = $clog2(MAX_IMG_RES + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        continuous,
  input  logic [CW-1:0]               cfg_width,
  input  logic [CW-1:0]               cfg_height,
  input  logic [1:0]                  cfg_pattern,
  input  logic [23:0]                 cfg_color,
  stream_video_pattern_gen_if.master  m_axis_video,
  output logic                        busy,
  output logic                        frame_done
);

  localparam int GW = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   x_q, y_q, x_n, y_n;
  logic [7:0]      frm_q, frm_n;
  logic [23:0]     ramp_q, ramp_n;
  logic [GW-1:0]   gap_q, gap_n;
  logic            stop_pending_q;
  logic            adv, load, done_n, hs, stop_any;

  logic [CW-1:0]   w_q, h_q;
  logic [1:0]      pat_q;
  logic [23:0]     color_q;
  logic            cont_q;

  logic [CW-1:0]   e_w;
  logic [1:0]      e_pat;
  logic [23:0]     e_color;

  logic [23:0]     tdata_q;
  logic            tvalid_q, tuser_q, tlast_q;

  function automatic logic [CW-1:0] clamp_res(input logic [CW-1:0] v);
    return (32'(v) > 32'(MAX_IMG_RES)) ? CW'(MAX_IMG_RES) : v;
  endfunction

  function automatic logic [23:0] pixel_value(input logic [1:0] pat, input logic [CW-1:0] px,
                                              input logic [CW-1:0] py, input logic [7:0] f,
                                              input logic [23:0] color, input logic [23:0] ramp);
    logic [15:0] xe, ye;
    xe = 16'(px);
    ye = 16'(py);
    case (pat)
      2'd0:    return {xe[7:0], ye[7:0], f};
      2'd1:    return color;
      2'd2:    return (xe[3] ^ ye[3]) ? 24'hFFFFFF : 24'h000000;
      default: return ramp;
    endcase
  endfunction

  // The first pixel of a frame is formed in the same edge that latches the configuration.
  assign e_w     = (state == IDLE) ? clamp_res(cfg_width) : w_q;
  assign e_pat   = (state == IDLE) ? cfg_pattern : pat_q;
  assign e_color = (state == IDLE) ? cfg_color : color_q;

  assign hs       = tvalid_q & m_axis_video.tready;
  assign stop_any = stop_pending_q | stop;

  always_comb begin
    state_n = state;
    adv     = 1'b0;
    load    = 1'b0;
    done_n  = 1'b0;
    x_n     = x_q;
    y_n     = y_q;
    frm_n   = frm_q;
    ramp_n  = ramp_q;
    gap_n   = gap_q;
    case (state)
      IDLE: begin
        if (start && (cfg_width != '0) && (cfg_height != '0)) begin
          state_n = ACTIVE;
          load    = 1'b1;
          adv     = 1'b1;
          x_n     = '0;
          y_n     = '0;
          frm_n   = '0;
          ramp_n  = '0;
        end
      end
      ACTIVE: begin
        if (hs) begin
          ramp_n = ramp_q + 24'd1;
          if (x_q == w_q - CW'(1)) begin
            x_n = '0;
            if (y_q == h_q - CW'(1)) begin
              y_n    = '0;
              ramp_n = '0;
              frm_n  = frm_q + 8'd1;
              done_n = 1'b1;
              if (cont_q && !stop_any) begin
                if (FRAME_GAP == 0) begin
                  adv = 1'b1;
                end else begin
                  state_n = GAP;
                  gap_n   = '0;
                end
              end else begin
                state_n = IDLE;
              end
            end else begin
              y_n = y_q + CW'(1);
              adv = 1'b1;
            end
          end else begin
            x_n = x_q + CW'(1);
            adv = 1'b1;
          end
        end
      end
      GAP: begin
        if (stop_any) begin
          state_n = IDLE;
        end else if (gap_q == GW'(FRAME_GAP - 1)) begin
          state_n = ACTIVE;
          adv     = 1'b1;
        end else begin
          gap_n = gap_q + GW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      x_q            <= '0;
      y_q            <= '0;
      frm_q          <= '0;
      ramp_q         <= '0;
      gap_q          <= '0;
      stop_pending_q <= 1'b0;
      tvalid_q       <= 1'b0;
      tdata_q        <= '0;
      tuser_q        <= 1'b0;
      tlast_q        <= 1'b0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      state          <= state_n;
      x_q            <= x_n;
      y_q            <= y_n;
      frm_q          <= frm_n;
      ramp_q         <= ramp_n;
      gap_q          <= gap_n;
      stop_pending_q <= (state_n == IDLE) ? 1'b0 : (stop_pending_q | (stop && (state != IDLE)));
      tvalid_q       <= (state_n == ACTIVE);
      busy           <= (state_n != IDLE);
      frame_done     <= done_n;
      if (adv) begin
        tdata_q <= pixel_value(e_pat, x_n, y_n, frm_n, e_color, ramp_n);
        tuser_q <= (x_n == '0) && (y_n == '0);
        tlast_q <= (x_n == e_w - CW'(1));
      end else if (state_n != ACTIVE) begin
        tuser_q <= 1'b0;
        tlast_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      w_q     <= clamp_res(cfg_width);
      h_q     <= clamp_res(cfg_height);
      pat_q   <= cfg_pattern;
      color_q <= cfg_color;
      cont_q  <= continuous;
    end
  end

  assign m_axis_video.tdata  = tdata_q;
  assign m_axis_video.tvalid = tvalid_q;
  assign m_axis_video.tuser  = tuser_q;
  assign m_axis_video.tlast  = tlast_q;

endmodule
